// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment display write path.
package disp_pkg;
  localparam int CODE_W    = 5;
  localparam int SLOT_W    = 2;
  localparam int NUM_SLOTS = 4;

  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;
  localparam logic [7:0]        CTRL_IDLE  = 8'hFF;

  typedef enum logic [2:0] {IDLE, EVAL, SETUP, STROBE, HOLD, DONE} state_e;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [NUM_SLOTS-1:0][CODE_W-1:0] code_vec_t;

  function automatic logic [7:0] ctrl_word(input logic strobe_n, input logic [SLOT_W-1:0] slot,
                                           input code_t code);
    return {strobe_n, slot, code};
  endfunction
endpackage

// File: rtl/disp_code_encoder.sv
// Combinational hex value to per-slot display codes, with optional leading-zero blanking.
module disp_code_encoder
  import disp_pkg::*;
(
  input  logic [15:0] in_value,
  input  logic        in_blank_lz,
  output code_vec_t   codes
);
  logic       zero_run;
  logic [3:0] nib;

  always_comb begin
    codes    = '0;
    zero_run = in_blank_lz;
    nib      = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      nib      = in_value[15-4*k -: 4];
      zero_run = zero_run & (nib == 4'h0);
      // The rightmost slot always shows a digit so zero never renders as all blank.
      if (zero_run && (k < NUM_SLOTS - 1)) codes[k] = CODE_BLANK;
      else                                 codes[k] = {1'b0, nib};
    end
  end
endmodule

// File: rtl/disp_update_sequencer.sv
// Sequences one strobed ctrl write per changed display slot; a shadow of written codes skips unchanged slots.
module disp_update_sequencer
  import disp_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_value,
  input  logic        in_blank_lz,
  input  logic        in_force,
  output logic [7:0]  ctrl,
  output logic        busy,
  output logic        done
);
  localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   digit_q, digit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  code_vec_t           code_q, code_d;
  code_vec_t           shadow_q, shadow_d;
  logic                force_q, force_d;
  logic                shadow_inv_q, shadow_inv_d;
  logic [7:0]          ctrl_q, ctrl_d;
  code_vec_t           enc_codes;
  logic                last_digit;

  disp_code_encoder u_enc (
    .in_value   (in_value),
    .in_blank_lz(in_blank_lz),
    .codes      (enc_codes)
  );

  assign in_ready   = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign ctrl       = ctrl_q;
  assign last_digit = (digit_q == SLOT_W'(NUM_SLOTS - 1));

  // ctrl_d tracks the state being entered so the registered ctrl lines up with state_q.
  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    shadow_d     = shadow_q;
    force_d      = force_q;
    shadow_inv_d = shadow_inv_q;
    ctrl_d       = CTRL_IDLE;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          code_d  = enc_codes;
          force_d = in_force;
          digit_d = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (force_q || shadow_inv_q || (code_q[digit_q] != shadow_q[digit_q])) begin
          state_d = SETUP;
          ctrl_d  = ctrl_word(1'b1, digit_q, code_q[digit_q]);
        end else if (last_digit) begin
          state_d = DONE;
        end else begin
          digit_d = digit_q + 2'd1;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_W'(STROBE_CYCLES);
        ctrl_d  = ctrl_word(1'b0, digit_q, code_q[digit_q]);
      end
      STROBE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
          ctrl_d  = ctrl_word(1'b1, digit_q, code_q[digit_q]);
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          ctrl_d = ctrl_word(1'b0, digit_q, code_q[digit_q]);
        end
      end
      HOLD: begin
        shadow_d[digit_q] = code_q[digit_q];
        if (last_digit) begin
          state_d = DONE;
        end else begin
          digit_d = digit_q + 2'd1;
          state_d = EVAL;
        end
      end
      DONE: begin
        shadow_inv_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      digit_q      <= '0;
      cnt_q        <= '0;
      code_q       <= {NUM_SLOTS{CODE_BLANK}};
      shadow_q     <= {NUM_SLOTS{CODE_BLANK}};
      force_q      <= 1'b0;
      shadow_inv_q <= 1'b1;
      ctrl_q       <= CTRL_IDLE;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      force_q      <= force_d;
      shadow_inv_q <= shadow_inv_d;
      ctrl_q       <= ctrl_d;
    end
  end
endmodule

// File: tb/tb_disp_update_sequencer.sv
// Directed bench for disp_update_sequencer: strobe values, strobe width, DONE latency, reset and hold-off.
module tb_disp_update_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic        in_blank_lz;
  logic        in_force;
  logic [7:0]  ctrl;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] stb[$];
  int         lows[$];
  int         done_cyc;
  int         stable_err;

  disp_update_sequencer #(.STROBE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_blank_lz(in_blank_lz),
    .in_force   (in_force),
    .ctrl       (ctrl),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watches cycles c1.. after a handshake edge, recording each strobe's ctrl word and low width.
  task automatic monitor(input int budget);
    logic [7:0] prev;
    logic [6:0] held;
    logic       active;
    stb.delete();
    lows.delete();
    done_cyc   = -1;
    stable_err = 0;
    prev       = 8'hFF;
    held       = '0;
    active     = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_not_ready_c1", {30'd0, busy, in_ready}, 32'd2);
      if (ctrl != 8'hFF && !active) begin
        active = 1'b1;
        held   = ctrl[6:0];
      end else if (active && ctrl == 8'hFF) begin
        active = 1'b0;
      end else if (active && ctrl[6:0] != held) begin
        stable_err++;
      end
      if (!ctrl[7] && prev[7]) begin
        stb.push_back(ctrl);
        lows.push_back(1);
      end else if (!ctrl[7] && lows.size() > 0) begin
        lows[lows.size()-1]++;
      end
      prev = ctrl;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input int n, input logic [31:0] exp, input int exp_done);
    logic [7:0] o;
    int         l;
    check($sformatf("%s_nstrobe", tag), stb.size(), n);
    for (int i = 0; i < n; i++) begin
      o = (i < stb.size()) ? stb[i] : 8'hxx;
      l = (i < lows.size()) ? lows[i] : 0;
      check($sformatf("%s_ctrl%0d", tag, i), {24'd0, o}, {24'd0, exp[31-8*i -: 8]});
      check($sformatf("%s_low%0d", tag, i), l, 2);
    end
    check($sformatf("%s_done_cyc", tag), done_cyc, exp_done);
    check($sformatf("%s_stable", tag), stable_err, 0);
  endtask

  task automatic run_update(input logic [15:0] v, input logic lz, input logic f);
    in_value    = v;
    in_blank_lz = lz;
    in_force    = f;
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    monitor(40);
  endtask

  task automatic check_ready_after(input string tag);
    @(negedge clk);
    check(tag, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_value    = '0;
    in_blank_lz = 1'b0;
    in_force    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {24'd0, ctrl}, 32'hFF);
    check("rst_busy_done_ready", {29'd0, busy, done, in_ready}, 32'd0);
    rst = 1'b0;
    #1 check("rel_ready", {31'd0, in_ready}, 32'd1);

    // Fresh after reset: every slot written.
    run_update(16'h1234, 1'b0, 1'b0);
    check_run("t1", 4, 32'h01_22_43_64, 21);
    check_ready_after("t1_ready_c22");

    // Same value again: all slots skip.
    run_update(16'h1234, 1'b0, 1'b0);
    check_run("t2_skip", 0, 32'h0, 5);
    check_ready_after("t2_ready_c6");

    run_update(16'h1234, 1'b0, 1'b1);
    check_run("t2_force", 4, 32'h01_22_43_64, 21);
    check_ready_after("t2f_ready");

    run_update(16'h0050, 1'b1, 1'b0);
    check_run("t3", 4, 32'h10_30_45_60, 21);
    check_ready_after("t3_ready");

    // Shadow holds 10,10,05,00; only slot2 changes to blank.
    run_update(16'h0000, 1'b1, 1'b0);
    check_run("t4a", 1, 32'h50_00_00_00, 9);
    check_ready_after("t4a_ready");

    run_update(16'h0001, 1'b1, 1'b0);
    check_run("t4b", 1, 32'h61_00_00_00, 9);
    check_ready_after("t4b_ready");

    // Reset during slot1 strobe (c8 of a forced write).
    in_value = 16'h1234;
    in_blank_lz = 1'b0;
    in_force = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_mid_strobe", {24'd0, ctrl}, 32'h22);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ctrl", {24'd0, ctrl}, 32'hFF);
    check("t5_rst_busy_ready", {30'd0, busy, in_ready}, 32'd0);
    rst = 1'b0;
    #1 check("t5_rel_ready", {31'd0, in_ready}, 32'd1);
    run_update(16'h0050, 1'b1, 1'b0);
    check_run("t5", 4, 32'h10_30_45_60, 21);
    check_ready_after("t5_ready");

    // Request held high across a busy sequence; value changed after acceptance.
    in_value = 16'h5678;
    in_blank_lz = 1'b0;
    in_force = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_value = 16'hABCD;
    monitor(40);
    check_run("t6a", 4, 32'h05_26_47_68, 21);
    check_ready_after("t6_ready_c22");
    @(posedge clk);
    #1 in_valid = 1'b0;
    monitor(40);
    check_run("t6b", 4, 32'h0A_2B_4C_6D, 21);
    check_ready_after("t6b_ready");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
